// File: rtl/gb_vga_scaler.sv
// gb_vga_scaler
//   Pixel-fetch stage that sits behind the VGA timing generator. Scales the
//   160x144 Game Boy framebuffer by 3 into a centred 480x432 window of the
//   640x480 frame. It fetches one 2-bit shade per window pixel from a
//   synchronous RAM and drives palette RGB. Sync and blank are delayed to
//   line up with the colour.
//
// Ports
//   Clk                   pixel clock (shared with the timing generator)
//   Reset_n               asynchronous active-low reset
//   DrawX[9:0]            current column 0..799
//   DrawY[9:0]            current line 0..524
//   hs_in, vs_in          active-low syncs aligned with DrawX/DrawY
//   blank_in              1 = visible pixel
//   fb_addr[14:0]         framebuffer read address gy*160+gx (registered)
//   fb_rd                 read enable, high for window pixels (registered)
//   fb_data[1:0]          shade from the RAM, one clock after fb_addr
//   VGA_R/G/B[7:0]        registered colour
//   hs_out, vs_out,       syncs/blank delayed to match the colour
//   blank_out
//
// Latency: 3 clocks from inputs to VGA_*/hs_out/vs_out/blank_out;
// fb_addr/fb_rd lead the colour by 2 clocks.
module gb_vga_scaler (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic [9:0]  DrawX,
  input  logic [9:0]  DrawY,
  input  logic        hs_in,
  input  logic        vs_in,
  input  logic        blank_in,
  output logic [14:0] fb_addr,
  output logic        fb_rd,
  input  logic [1:0]  fb_data,
  output logic [7:0]  VGA_R,
  output logic [7:0]  VGA_G,
  output logic [7:0]  VGA_B,
  output logic        hs_out,
  output logic        vs_out,
  output logic        blank_out
);

  localparam logic [9:0]  X0       = 10'd80;
  localparam logic [9:0]  X_END    = 10'd560;   // X0 + 480
  localparam logic [9:0]  Y0       = 10'd24;
  localparam logic [9:0]  Y_END    = 10'd456;   // Y0 + 432
  localparam logic [9:0]  Y_LAST   = 10'd455;   // last line of the window
  localparam logic [9:0]  LINE_END = 10'd799;
  localparam logic [7:0]  GX_MAX   = 8'd159;
  localparam logic [7:0]  GY_MAX   = 8'd143;
  localparam logic [14:0] ROW_STEP = 15'd160;

  localparam logic [23:0] PAL0   = 24'hE0F8D0;
  localparam logic [23:0] PAL1   = 24'h88C070;
  localparam logic [23:0] PAL2   = 24'h346856;
  localparam logic [23:0] PAL3   = 24'h081820;
  localparam logic [23:0] BORDER = 24'h000000;

  // Window flags
  logic hwin, vwin, win, vadv, line_end;

  assign hwin     = (DrawX >= X0) && (DrawX < X_END);
  assign vwin     = (DrawY >= Y0) && (DrawY < Y_END);
  assign win      = hwin && vwin;
  // Vertical counters advance on lines Y0..Y0+430 only; the last window line
  // falls into the clear branch so gy never steps past 143.
  assign vadv     = (DrawY >= Y0) && (DrawY < Y_LAST);
  assign line_end = (DrawX == LINE_END);

  // Scaling counters
  logic [1:0]  sx_reg, sx_next;
  logic [7:0]  gx_reg, gx_next;
  logic [1:0]  sy_reg, sy_next;
  logic [7:0]  gy_reg, gy_next;
  logic [14:0] row_base_reg, row_base_next;

  always_comb begin
    sx_next       = sx_reg;
    gx_next       = gx_reg;
    sy_next       = sy_reg;
    gy_next       = gy_reg;
    row_base_next = row_base_reg;

    if (!hwin) begin
      sx_next = 2'd0;
      gx_next = 8'd0;
    end else if (sx_reg == 2'd2) begin
      sx_next = 2'd0;
      // Saturation only matters after a mid-frame reset; it keeps the
      // address inside the framebuffer while the counters are out of step.
      if (gx_reg != GX_MAX) gx_next = gx_reg + 8'd1;
    end else begin
      sx_next = sx_reg + 2'd1;
    end

    if (line_end) begin
      if (vadv) begin
        if (sy_reg == 2'd2) begin
          sy_next = 2'd0;
          if (gy_reg != GY_MAX) begin
            gy_next       = gy_reg + 8'd1;
            row_base_next = row_base_reg + ROW_STEP;
          end
        end else begin
          sy_next = sy_reg + 2'd1;
        end
      end else begin
        sy_next       = 2'd0;
        gy_next       = 8'd0;
        row_base_next = 15'd0;
      end
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      sx_reg       <= 2'd0;
      gx_reg       <= 8'd0;
      sy_reg       <= 2'd0;
      gy_reg       <= 8'd0;
      row_base_reg <= 15'd0;
    end else begin
      sx_reg       <= sx_next;
      gx_reg       <= gx_next;
      sy_reg       <= sy_next;
      gy_reg       <= gy_next;
      row_base_reg <= row_base_next;
    end
  end

  // Stage 1: address issue, uses the counter values before this clock's update
  logic fb_rd_reg, win_d1_reg, hs_d1_reg, vs_d1_reg, blank_d1_reg;
  logic [14:0] fb_addr_reg;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      fb_addr_reg  <= 15'd0;
      fb_rd_reg    <= 1'b0;
      win_d1_reg   <= 1'b0;
      hs_d1_reg    <= 1'b1;
      vs_d1_reg    <= 1'b1;
      blank_d1_reg <= 1'b0;
    end else begin
      if (win) fb_addr_reg <= row_base_reg + {7'd0, gx_reg};
      fb_rd_reg    <= win;
      win_d1_reg   <= win;
      hs_d1_reg    <= hs_in;
      vs_d1_reg    <= vs_in;
      blank_d1_reg <= blank_in;
    end
  end

  assign fb_addr = fb_addr_reg;
  assign fb_rd   = fb_rd_reg;

  // Stage 2: the RAM is reading; carry the flags along
  logic win_d2_reg, hs_d2_reg, vs_d2_reg, blank_d2_reg;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      win_d2_reg   <= 1'b0;
      hs_d2_reg    <= 1'b1;
      vs_d2_reg    <= 1'b1;
      blank_d2_reg <= 1'b0;
    end else begin
      win_d2_reg   <= win_d1_reg;
      hs_d2_reg    <= hs_d1_reg;
      vs_d2_reg    <= vs_d1_reg;
      blank_d2_reg <= blank_d1_reg;
    end
  end

  // Stage 3: palette lookup and colour register
  logic [23:0] pal_rgb;
  logic [23:0] rgb_reg;
  logic        hs_out_reg, vs_out_reg, blank_out_reg;

  always_comb begin
    pal_rgb = PAL0;
    case (fb_data)
      2'd0:    pal_rgb = PAL0;
      2'd1:    pal_rgb = PAL1;
      2'd2:    pal_rgb = PAL2;
      default: pal_rgb = PAL3;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      rgb_reg       <= 24'd0;
      hs_out_reg    <= 1'b1;
      vs_out_reg    <= 1'b1;
      blank_out_reg <= 1'b0;
    end else begin
      if (!blank_d2_reg)   rgb_reg <= 24'd0;
      else if (win_d2_reg) rgb_reg <= pal_rgb;
      else                 rgb_reg <= BORDER;
      hs_out_reg    <= hs_d2_reg;
      vs_out_reg    <= vs_d2_reg;
      blank_out_reg <= blank_d2_reg;
    end
  end

  assign VGA_R     = rgb_reg[23:16];
  assign VGA_G     = rgb_reg[15:8];
  assign VGA_B     = rgb_reg[7:0];
  assign hs_out    = hs_out_reg;
  assign vs_out    = vs_out_reg;
  assign blank_out = blank_out_reg;

endmodule
